// File: rtl/arb_dm_axil_req.sv
// arb_dm_axil_req: two-port round-robin request arbiter in front of a
// req/gnt-to-AXI-lite bridge. One transaction is in flight at a time.
// The flow is IDLE (arbitrate) -> BUSY (s_req_o high) -> RELEASE (one idle
// cycle) -> IDLE.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a BUSY phase
// that lasts TIMEOUT_CYCLES cycles without s_gnt_i is force-completed. The
// forced completion returns 32'hDEAD_BEEF for reads and pulses timeout_o.
`timescale 1ns/1ps
module arb_dm_axil_req #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic [31:0] m0_add_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_be_i,
    output logic        m0_gnt_o,
    output logic        m0_r_valid_o,
    output logic [31:0] m0_r_rdata_o,
    input  logic        m1_req_i,
    input  logic [31:0] m1_add_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_be_i,
    output logic        m1_gnt_o,
    output logic        m1_r_valid_o,
    output logic [31:0] m1_r_rdata_o,
    output logic        s_req_o,
    output logic [31:0] s_add_o,
    output logic        s_we_o,
    output logic [31:0] s_wdata_o,
    output logic [3:0]  s_be_o,
    input  logic        s_gnt_i,
    input  logic [31:0] s_rdata_i,
    output logic        owner_o,
    output logic        busy_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner;
    logic [31:0] r_s_add;
    logic [31:0] r_s_wdata;
    logic        r_s_we;
    logic [3:0]  r_s_be;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;

    logic        w_arb;        // arbitration happens this cycle
    logic        w_win;        // winning port (0 = m0, 1 = m1)
    logic        w_s_req;
    logic        w_busy;
    logic        w_to_hit;     // forced completion this cycle
    logic        w_done;       // transaction completes this cycle
    logic [31:0] w_done_rdata; // read data returned on completion

    // On a tie, the port that did not own the last transaction wins.
    assign w_win = (m0_req_i && m1_req_i) ? ~r_owner : m1_req_i;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_to_cnt;

    // Timeout counter: counts BUSY cycles without s_gnt_i and is cleared outside BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= 8'd0;
        end else if (r_state != ST_BUSY) begin
            r_to_cnt <= 8'd0;
        end else if (!s_gnt_i) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    // A real grant always wins over a timeout that falls in the same cycle.
    assign w_to_hit     = (r_state == ST_BUSY) && !rst && !s_gnt_i && (r_to_cnt == TO_LAST);
    assign w_done_rdata = s_gnt_i ? s_rdata_i : 32'hDEAD_BEEF;
`else
    assign w_to_hit     = 1'b0;
    assign w_done_rdata = s_rdata_i;
`endif

    // Completion pulses are suppressed while reset is high, so an aborted
    // transaction never reports as done.
    assign w_done = (r_state == ST_BUSY) && !rst && (s_gnt_i || w_to_hit);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state always uses non-blocking (<=) so every register
        // samples pre-edge values; blocking here would create order races.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded controls.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_arb       = 1'b0;
        w_s_req     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_arb = m0_req_i || m1_req_i;
                if (w_arb) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_s_req = 1'b1;
                w_busy  = 1'b1;
                if (w_done) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_busy      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the winner's transaction, track the owner, and capture read data on completion.
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset as well, because downstream logic
        // may observe s_* and r_rdata before the first transaction.
        if (rst) begin
            r_owner    <= 1'b1;
            r_s_add    <= 32'd0;
            r_s_wdata  <= 32'd0;
            r_s_we     <= 1'b0;
            r_s_be     <= 4'd0;
            r_m0_rdata <= 32'd0;
            r_m1_rdata <= 32'd0;
        end else begin
            if (w_arb) begin
                r_owner   <= w_win;
                r_s_add   <= w_win ? m1_add_i   : m0_add_i;
                r_s_wdata <= w_win ? m1_wdata_i : m0_wdata_i;
                r_s_we    <= w_win ? m1_we_i    : m0_we_i;
                r_s_be    <= w_win ? m1_be_i    : m0_be_i;
            end
            if (w_done && !r_s_we) begin
                if (r_owner) begin
                    r_m1_rdata <= w_done_rdata;
                end else begin
                    r_m0_rdata <= w_done_rdata;
                end
            end
        end
    end

    assign s_req_o      = w_s_req;
    assign s_add_o      = r_s_add;
    assign s_wdata_o    = r_s_wdata;
    assign s_we_o       = r_s_we;
    assign s_be_o       = r_s_be;
    assign owner_o      = r_owner;
    assign busy_o       = w_busy;
    assign timeout_o    = w_to_hit;
    assign m0_gnt_o     = w_done && !r_owner;
    assign m1_gnt_o     = w_done &&  r_owner;
    assign m0_r_valid_o = w_done && !r_owner && !r_s_we;
    assign m1_r_valid_o = w_done &&  r_owner && !r_s_we;
    assign m0_r_rdata_o = r_m0_rdata;
    assign m1_r_rdata_o = r_m1_rdata;

endmodule
